branch_resolve_unit: RTL and testbench

- Resolves branches in ex0 and is the producer for the BTB update/feedback interface.
- Per resolved instruction it computes the real direction and target, and compares them against the prediction carried down the pipe.
- Drives fact_pc/fact_tpc/fact_taken/predict_dir_fail/predict_add_fail back to the BTB, plus the front-end redirect.
- Squashes wrong-path instructions for a fixed shadow window after a redirect, and keeps misprediction statistics.

---
 rtl/branch_resolve_unit.sv | 177 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution in ex0: computes the real direction and target, grades the fetch-time
// prediction, feeds the BTB, redirects the front end and drains the wrong path afterwards.
module branch_resolve_unit #(
    parameter int SHADOW_CYCLES = 3,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ex_valid,
    input  logic                 ex_stall,
    input  logic [31:0]          ex_pc,
    input  logic [1:0]           ex_btype,
    input  logic [2:0]           ex_cmp_op,
    input  logic [31:0]          ex_src1,
    input  logic [31:0]          ex_src2,
    input  logic [31:0]          ex_offs,
    input  logic                 ex_pred_taken,
    input  logic [31:0]          ex_pred_pc,
    output logic [31:0]          fact_pc,
    output logic [31:0]          fact_tpc,
    output logic                 fact_taken,
    output logic                 predict_dir_fail,
    output logic                 predict_add_fail,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 in_shadow,
    output logic [CNT_WIDTH-1:0] br_total,
    output logic [CNT_WIDTH-1:0] br_dir_miss,
    output logic [CNT_WIDTH-1:0] br_add_miss
);

    localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        shadow_active;

    logic        accept;
    logic [31:0] seq_pc;
    logic [31:0] target;
    logic        cond_taken;
    logic        taken;
    logic        dir_fail;
    logic        add_fail;
    logic        redirect;
    logic        is_branch;

    assign accept = ex_valid & ~ex_stall & ~shadow_active;

    // Resolution datapath
    always_comb begin
        seq_pc = ex_pc + 32'd4;

        case (ex_btype)
            2'b00:   target = seq_pc;
            2'b11:   target = ex_src1 + ex_offs;
            default: target = ex_pc + ex_offs;
        endcase

        case (ex_cmp_op)
            3'b000:  cond_taken = (ex_src1 == ex_src2);
            3'b001:  cond_taken = (ex_src1 != ex_src2);
            3'b010:  cond_taken = ($signed(ex_src1) < $signed(ex_src2));
            3'b011:  cond_taken = !($signed(ex_src1) < $signed(ex_src2));
            3'b100:  cond_taken = (ex_src1 < ex_src2);
            3'b101:  cond_taken = !(ex_src1 < ex_src2);
            3'b110:  cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase

        case (ex_btype)
            2'b00:   taken = 1'b0;
            2'b10:   taken = cond_taken;
            default: taken = 1'b1;
        endcase

        // Target is only graded when direction was right, so the two flags never coincide
        dir_fail  = (ex_pred_taken != taken);
        add_fail  = taken & ex_pred_taken & (ex_pred_pc != target);
        redirect  = dir_fail | add_fail;
        is_branch = (ex_btype != 2'b00);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // FSM: next state; the drain counts wall-clock cycles, stalls do not extend it
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept && redirect && (SHADOW_LOAD != 4'd0)) begin
                    state_next = SHADOW;
                    cnt_next   = SHADOW_LOAD;
                end
            end
            SHADOW: begin
                if (cnt_reg <= 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        shadow_active = (state_reg == SHADOW);
    end

    assign in_shadow = shadow_active;

    // BTB feedback and redirect; fact_* and redirect_pc hold between accepts
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fact_pc          <= 32'd0;
            fact_tpc         <= 32'd0;
            fact_taken       <= 1'b0;
            predict_dir_fail <= 1'b0;
            predict_add_fail <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= 32'd0;
        end else begin
            predict_dir_fail <= accept & dir_fail;
            predict_add_fail <= accept & add_fail;
            redirect_valid   <= accept & redirect;
            if (accept) begin
                fact_pc    <= ex_pc;
                fact_tpc   <= target;
                fact_taken <= taken;
                if (redirect) begin
                    redirect_pc <= taken ? target : seq_pc;
                end
            end
        end
    end

    // Saturating statistics: [0] total branches, [1] direction misses, [2] target misses
    logic [2:0] stat_inc;
    assign stat_inc = {accept & add_fail, accept & dir_fail, accept & is_branch};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [CNT_WIDTH-1:0] stat_reg;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stat_reg <= '0;
            end else if (stat_inc[gi] && (stat_reg != {CNT_WIDTH{1'b1}})) begin
                stat_reg <= stat_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign br_total    = g_stat[0].stat_reg;
    assign br_dir_miss = g_stat[1].stat_reg;
    assign br_add_miss = g_stat[2].stat_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a reference model pushes expected results per
// cycle into a scoreboard queue, popped and compared one cycle after each drive.
module tb_branch_resolve_unit;

    localparam int SH = 3;
    localparam int CW = 4;

    logic          clk;
    logic          rstn;
    logic          ex_valid, ex_stall;
    logic [31:0]   ex_pc, ex_src1, ex_src2, ex_offs, ex_pred_pc;
    logic [1:0]    ex_btype;
    logic [2:0]    ex_cmp_op;
    logic          ex_pred_taken;
    logic [31:0]   fact_pc, fact_tpc, redirect_pc;
    logic          fact_taken, predict_dir_fail, predict_add_fail, redirect_valid, in_shadow;
    logic [CW-1:0] br_total, br_dir_miss, br_add_miss;

    branch_resolve_unit #(.SHADOW_CYCLES(SH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_btype(ex_btype),
        .ex_cmp_op(ex_cmp_op), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_offs(ex_offs),
        .ex_pred_taken(ex_pred_taken), .ex_pred_pc(ex_pred_pc),
        .fact_pc(fact_pc), .fact_tpc(fact_tpc), .fact_taken(fact_taken),
        .predict_dir_fail(predict_dir_fail), .predict_add_fail(predict_add_fail),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_shadow(in_shadow),
        .br_total(br_total), .br_dir_miss(br_dir_miss), .br_add_miss(br_add_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   fpc;
        logic [31:0]   ftpc;
        logic          ftk;
        logic          df;
        logic          af;
        logic          rv;
        logic [31:0]   rpc;
        logic          sh;
        logic [CW-1:0] tot;
        logic [CW-1:0] dm;
        logic [CW-1:0] am;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            m_shadow;
    logic [31:0]   m_fpc, m_ftpc, m_rpc;
    logic          m_ftk;
    logic [CW-1:0] m_tot, m_dm, m_am;

    task automatic model_reset();
        m_shadow = 0;
        m_fpc = '0; m_ftpc = '0; m_rpc = '0; m_ftk = 1'b0;
        m_tot = '0; m_dm = '0; m_am = '0;
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + CW'(1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare at posedge+1
    task automatic step(input logic v, input logic st, input logic [31:0] pc,
                        input logic [1:0] bt, input logic [2:0] op,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] of,
                        input logic pt, input logic [31:0] ppc);
        exp_t        e;
        logic        acc, tk, df, af;
        logic [31:0] tg;
        ex_valid = v; ex_stall = st; ex_pc = pc; ex_btype = bt; ex_cmp_op = op;
        ex_src1 = s1; ex_src2 = s2; ex_offs = of; ex_pred_taken = pt; ex_pred_pc = ppc;

        acc = v && !st && (m_shadow == 0);
        case (bt)
            2'b00:   tg = pc + 32'd4;
            2'b11:   tg = s1 + of;
            default: tg = pc + of;
        endcase
        if (bt == 2'b00)      tk = 1'b0;
        else if (bt != 2'b10) tk = 1'b1;
        else begin
            case (op)
                3'd0:    tk = (s1 == s2);
                3'd1:    tk = (s1 != s2);
                3'd2:    tk = ($signed(s1) < $signed(s2));
                3'd3:    tk = ($signed(s1) >= $signed(s2));
                3'd4:    tk = (s1 < s2);
                3'd5:    tk = (s1 >= s2);
                3'd6:    tk = 1'b1;
                default: tk = 1'b0;
            endcase
        end
        df = acc && (pt != tk);
        af = acc && tk && pt && (ppc != tg);

        if (m_shadow > 0) m_shadow--;
        if (acc) begin
            m_fpc = pc; m_ftpc = tg; m_ftk = tk;
            if (df || af) begin
                m_rpc = tk ? tg : pc + 32'd4;
                if (SH > 0) m_shadow = SH;
            end
            if (bt != 2'b00) m_tot = sat_inc(m_tot);
            if (df)          m_dm  = sat_inc(m_dm);
            if (af)          m_am  = sat_inc(m_am);
        end
        e = '{fpc: m_fpc, ftpc: m_ftpc, ftk: m_ftk, df: df, af: af, rv: df | af,
              rpc: m_rpc, sh: (m_shadow > 0), tot: m_tot, dm: m_dm, am: m_am};
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("step pc=%h bt=%0d acc=%0d: fact_pc=%h tpc=%h tk=%0d df=%0d af=%0d rv=%0d sh=%0d tot=%0d dm=%0d am=%0d",
                 pc, bt, acc, fact_pc, fact_tpc, fact_taken, predict_dir_fail, predict_add_fail,
                 redirect_valid, in_shadow, br_total, br_dir_miss, br_add_miss);
        chk("fact_pc",    fact_pc, e.fpc);
        chk("fact_tpc",   fact_tpc, e.ftpc);
        chk("fact_taken", 32'(fact_taken), 32'(e.ftk));
        chk("dir_fail",   32'(predict_dir_fail), 32'(e.df));
        chk("add_fail",   32'(predict_add_fail), 32'(e.af));
        chk("redirect",   32'(redirect_valid), 32'(e.rv));
        if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
        chk("in_shadow",  32'(in_shadow), 32'(e.sh));
        chk("br_total",   32'(br_total), 32'(e.tot));
        chk("br_dir_miss", 32'(br_dir_miss), 32'(e.dm));
        chk("br_add_miss", 32'(br_add_miss), 32'(e.am));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 2'b00, 3'd0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fact_pc"}, fact_pc, 32'h0);
        chk({tag, "_fact_tpc"}, fact_tpc, 32'h0);
        chk({tag, "_fact_taken"}, 32'(fact_taken), 32'h0);
        chk({tag, "_pulses"}, 32'({predict_dir_fail, predict_add_fail, redirect_valid}), 32'h0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        chk({tag, "_in_shadow"}, 32'(in_shadow), 32'h0);
        chk({tag, "_counters"}, 32'({br_total, br_dir_miss, br_add_miss}), 32'h0);
    endtask

    initial begin
        rstn = 1'b0;
        ex_valid = 0; ex_stall = 0; ex_pc = 0; ex_btype = 0; ex_cmp_op = 0;
        ex_src1 = 0; ex_src2 = 0; ex_offs = 0; ex_pred_taken = 0; ex_pred_pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        idle(1);

        // Correctly predicted taken beq
        step(1, 0, 32'h1C00_0000, 2'b10, 3'd0, 5, 5, 32'h40, 1, 32'h1C00_0040);
        // Not-taken beq predicted taken: redirect, then shadow drops valid instructions
        step(1, 0, 32'h1C00_0000, 2'b10, 3'd0, 5, 6, 32'h40, 1, 32'h1C00_0040);
        for (int i = 0; i < SH; i++)
            step(1, 0, 32'h0000_0500, 2'b01, 3'd6, 0, 0, 32'h20, 0, 32'h0);
        step(1, 0, 32'h0000_0200, 2'b01, 3'd6, 0, 0, 32'h20, 1, 32'h0000_0220);

        // Indirect with wrong predicted target
        step(1, 0, 32'h0000_0600, 2'b11, 3'd6, 32'h8000_1000, 0, 32'h10, 1, 32'h8000_2000);
        idle(SH);
        // Non-branch predicted taken
        step(1, 0, 32'h0000_0100, 2'b00, 3'd0, 0, 0, 0, 1, 32'h0000_0200);
        idle(SH);

        // Signed versus unsigned compare on the same operands
        step(1, 0, 32'h0000_0300, 2'b10, 3'd2, 32'hFFFF_FFFF, 1, 32'h8, 1, 32'h0000_0308);
        step(1, 0, 32'h0000_0300, 2'b10, 3'd4, 32'hFFFF_FFFF, 1, 32'h8, 0, 32'h0);
        step(1, 0, 32'h0000_0310, 2'b10, 3'd3, 32'hFFFF_FFFF, 1, 32'h8, 0, 32'h0);
        step(1, 0, 32'h0000_0320, 2'b10, 3'd5, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 1, 32'h0000_0310);
        step(1, 0, 32'h0000_0330, 2'b10, 3'd7, 0, 0, 32'h8, 0, 32'h0);

        // Stalled instruction is evaluated once, on release
        step(1, 1, 32'h0000_0400, 2'b01, 3'd6, 0, 0, 32'h40, 1, 32'h0000_0440);
        step(1, 1, 32'h0000_0400, 2'b01, 3'd6, 0, 0, 32'h40, 1, 32'h0000_0440);
        step(1, 0, 32'h0000_0400, 2'b01, 3'd6, 0, 0, 32'h40, 1, 32'h0000_0440);
        idle(1);

        // Reset in the middle of a shadow window
        step(1, 0, 32'h0000_0700, 2'b10, 3'd1, 3, 3, 32'h10, 1, 32'h0000_0710);
        idle(1);
        ex_valid = 0;
        #2 rstn = 1'b0;
        #1;
        chk_all_zero("mid_shadow_reset");
        model_reset();
        #1 rstn = 1'b1;
        idle(1);
        step(1, 0, 32'h0000_0800, 2'b10, 3'd1, 3, 3, 32'h10, 1, 32'h0000_0810);
        idle(SH);

        // Drive the branch counter into saturation
        for (int i = 0; i < 18; i++)
            step(1, 0, 32'h0000_1000 + 32'(i * 4), 2'b01, 3'd6, 0, 0, 32'h80, 1,
                 32'h0000_1080 + 32'(i * 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a wedged simulation still terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
